// File: rtl/uart_pkg.sv
// Shared state encodings and baud constants for the UART receive/buffer/retransmit block.
package uart_pkg;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

    localparam int CLKS_PER_BIT_9600_12M = 1250;
    localparam int CLKS_PER_BIT_2400_12M = 5000;

endpackage

// File: rtl/uart_rx_fifo_tx_if.sv
// Serial lines, status flags and receive data of uart_rx_fifo_tx; slave is the block side.
interface uart_rx_fifo_tx_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int NW = $clog2(FIFO_DEPTH) + 1;

    logic                 rx;
    logic                 ovf_clr;
    logic                 tx;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 frame_err;
    logic                 overflow;
    logic [NW-1:0]        fifo_count;
    logic                 busy_rx;
    logic                 busy_tx;
    logic                 idle;

    modport slave (
        input  rx, ovf_clr,
        output tx, rx_valid, rx_data, frame_err, overflow, fifo_count, busy_rx, busy_tx, idle
    );

    modport master (
        output rx, ovf_clr,
        input  tx, rx_valid, rx_data, frame_err, overflow, fifo_count, busy_rx, busy_tx, idle
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only when a pop frees the slot.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo_tx.sv
// UART receiver with start/stop validation, FIFO buffering and retransmission,
// optionally gated by an inter-frame idle detector for burst draining.
module uart_rx_fifo_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_12M,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int IDLE_BITS    = 20,
    parameter int BURST        = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_fifo_tx_if.slave  bus
);
    localparam int CW         = $clog2(CLKS_PER_BIT);
    localparam int BW         = $clog2(DATA_BITS);
    localparam int NW         = $clog2(FIFO_DEPTH) + 1;
    localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int IW         = $clog2(IDLE_LIMIT + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_LIMIT);
    localparam logic [IW-1:0] IDLE_PRE  = IW'(IDLE_LIMIT - 1);

    logic                 r_sync1, r_sync2, w_rx_s;

    rx_state_t            r_rx_state, w_rx_state_n;
    logic [CW-1:0]        r_rx_clk, w_rx_clk_n;
    logic [BW-1:0]        r_rx_bit, w_rx_bit_n;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_n;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid, r_frame_err;
    logic                 w_rx_done, w_rx_ferr;

    logic [IW-1:0]        r_idle_cnt;
    logic                 r_idle;
    logic                 r_overflow;

    tx_state_t            r_tx_state, w_tx_state_n;
    logic [CW-1:0]        r_tx_clk, w_tx_clk_n;
    logic [BW-1:0]        r_tx_bit, w_tx_bit_n;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
    logic                 r_tx, w_tx_n;
    logic                 w_tx_en, w_pop;

    logic [DATA_BITS-1:0] w_fifo_data;
    logic                 w_fifo_full, w_fifo_empty, w_drop;
    logic [NW-1:0]        w_fifo_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx_s = r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state  <= R_IDLE;
            r_rx_clk    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_state_n;
            r_rx_clk    <= w_rx_clk_n;
            r_rx_bit    <= w_rx_bit_n;
            r_rx_shift  <= w_rx_shift_n;
            r_rx_valid  <= w_rx_done;
            r_frame_err <= w_rx_ferr;
            if (w_rx_done) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_clk_n   = r_rx_clk;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_done    = 1'b0;
        w_rx_ferr    = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                if (!w_rx_s) begin
                    w_rx_state_n = R_START;
                    w_rx_clk_n   = '0;
                    w_rx_bit_n   = '0;
                end
            end
            R_START: begin
                if (r_rx_clk == HALF_LAST) begin
                    w_rx_clk_n   = '0;
                    w_rx_state_n = w_rx_s ? R_IDLE : R_DATA;
                end else begin
                    w_rx_clk_n = r_rx_clk + 1'b1;
                end
            end
            R_DATA: begin
                if (r_rx_clk == BIT_LAST) begin
                    w_rx_clk_n   = '0;
                    w_rx_shift_n = {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == DATA_LAST) begin
                        w_rx_state_n = R_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_clk_n = r_rx_clk + 1'b1;
                end
            end
            R_STOP: begin
                if (r_rx_clk == BIT_LAST) begin
                    w_rx_clk_n = '0;
                    if (w_rx_s) begin
                        w_rx_done    = 1'b1;
                        w_rx_state_n = R_IDLE;
                    end else begin
                        w_rx_ferr    = 1'b1;
                        w_rx_state_n = R_BREAK;
                    end
                end else begin
                    w_rx_clk_n = r_rx_clk + 1'b1;
                end
            end
            R_BREAK: begin
                if (w_rx_s) begin
                    w_rx_state_n = R_IDLE;
                end
            end
            default: w_rx_state_n = R_IDLE;
        endcase
    end

    // idle is registered from the same condition that keeps RX in R_IDLE, so it
    // drops on the very edge the receiver leaves R_IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
            r_idle     <= 1'b0;
        end else if (r_rx_state == R_IDLE && w_rx_s) begin
            if (r_idle_cnt != IDLE_MAX) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            r_idle <= (r_idle_cnt >= IDLE_PRE);
        end else begin
            r_idle_cnt <= '0;
            r_idle     <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_done),
        .i_data  (r_rx_shift),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_drop = w_rx_done && w_fifo_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_tx_en = (BURST == 0) || r_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_tx_clk   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_clk   <= w_tx_clk_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx       <= w_tx_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_clk_n   = r_tx_clk;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_pop        = 1'b0;
        case (r_tx_state)
            T_IDLE: begin
                if (w_tx_en && !w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_tx_shift_n = w_fifo_data;
                    w_tx_clk_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_state_n = T_START;
                end
            end
            T_START: begin
                if (r_tx_clk == BIT_LAST) begin
                    w_tx_clk_n   = '0;
                    w_tx_state_n = T_DATA;
                end else begin
                    w_tx_clk_n = r_tx_clk + 1'b1;
                end
            end
            T_DATA: begin
                if (r_tx_clk == BIT_LAST) begin
                    w_tx_clk_n   = '0;
                    w_tx_shift_n = r_tx_shift >> 1;
                    if (r_tx_bit == DATA_LAST) begin
                        w_tx_state_n = T_STOP;
                    end else begin
                        w_tx_bit_n = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_clk_n = r_tx_clk + 1'b1;
                end
            end
            T_STOP: begin
                if (r_tx_clk == BIT_LAST) begin
                    w_tx_clk_n   = '0;
                    w_tx_state_n = T_IDLE;
                end else begin
                    w_tx_clk_n = r_tx_clk + 1'b1;
                end
            end
            default: w_tx_state_n = T_IDLE;
        endcase

        // Line level is registered from the next state so tx is glitch-free.
        w_tx_n = 1'b1;
        if (w_tx_state_n == T_START) begin
            w_tx_n = 1'b0;
        end else if (w_tx_state_n == T_DATA) begin
            w_tx_n = w_tx_shift_n[0];
        end
    end

    assign bus.tx         = r_tx;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.rx_data    = r_rx_data;
    assign bus.frame_err  = r_frame_err;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_count = w_fifo_count;
    assign bus.busy_rx    = (r_rx_state != R_IDLE);
    assign bus.busy_tx    = (r_tx_state != T_IDLE);
    assign bus.idle       = r_idle;

endmodule

// File: tb/tb_uart_rx_fifo_tx.sv
// Directed bench for uart_rx_fifo_tx: 16 clocks/bit, 8 data bits, 4-entry FIFO, 4 idle bits, burst mode.
module tb_uart_rx_fifo_tx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_valid = 0;
    int   n_ferr  = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus ();

    uart_rx_fifo_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (4),
        .IDLE_BITS    (4),
        .BURST        (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) n_valid++;
        if (bus.frame_err === 1'b1) n_ferr++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) tick();
        end
        bus.rx = stop_bit;
        repeat (CPB) tick();
    endtask

    task automatic wait_tx_low(input string tag, input int limit);
        int n;
        n = 0;
        while (bus.tx !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(n < limit), 32'd1);
    endtask

    task automatic recv_tx_byte(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        b = '0;
        wait_tx_low({tag, "_start_timeout"}, 400);
        repeat (CPB / 2) tick();
        check({tag, "_start"}, 32'(bus.tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            b[i] = bus.tx;
        end
        repeat (CPB) tick();
        check({tag, "_stop"}, 32'(bus.tx), 32'd1);
        check({tag, "_byte"}, 32'(b), 32'(exp));
    endtask

    initial begin
        int n;
        int v0;
        int f0;
        int lows;
        int exp_a5[10];
        exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        // 1. reset
        bus.rx      = 1'b1;
        bus.ovf_clr = 1'b0;
        rst         = 1'b1;
        repeat (3) tick();
        check("rst_tx",        32'(bus.tx),         32'd1);
        check("rst_count",     32'(bus.fifo_count), 32'd0);
        check("rst_rx_valid",  32'(bus.rx_valid),   32'd0);
        check("rst_rx_data",   32'(bus.rx_data),    32'd0);
        check("rst_frame_err", 32'(bus.frame_err),  32'd0);
        check("rst_overflow",  32'(bus.overflow),   32'd0);
        check("rst_busy_rx",   32'(bus.busy_rx),    32'd0);
        check("rst_busy_tx",   32'(bus.busy_tx),    32'd0);
        check("rst_idle",      32'(bus.idle),       32'd0);
        rst = 1'b0;
        n = 0;
        while (bus.idle !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("idle_latency_in_61_67", 32'(n >= 61 && n <= 67), 32'd1);

        // 2. receive 0xA5 and retransmit after the idle gap
        v0 = n_valid;
        send_frame(8'hA5, 1'b1);
        check("a5_valid_pulses", 32'(n_valid - v0),    32'd1);
        check("a5_rx_data",      32'(bus.rx_data),     32'hA5);
        check("a5_count",        32'(bus.fifo_count),  32'd1);
        wait_tx_low("a5_tx_timeout", 300);
        repeat (CPB / 2) tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("a5_tx_bit%0d", i), 32'(bus.tx), 32'(exp_a5[i]));
            if (i < 9) repeat (CPB) tick();
        end
        repeat (CPB / 2 + 2) tick();
        check("a5_count_drained", 32'(bus.fifo_count), 32'd0);
        check("a5_busy_tx_done",  32'(bus.busy_tx),    32'd0);

        // 3. start-bit glitch
        v0 = n_valid;
        f0 = n_ferr;
        bus.rx = 1'b0;
        repeat (4) tick();
        bus.rx = 1'b1;
        n = 0;
        while (bus.busy_rx !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("glitch_busy_rx_clear_le10", 32'(n <= 10), 32'd1);
        repeat (10) tick();
        check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
        check("glitch_no_ferr",  32'(n_ferr - f0),  32'd0);

        // 4. framing error then held break
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        repeat (40) tick();
        check("ferr_pulses",      32'(n_ferr - f0),    32'd1);
        check("ferr_no_valid",    32'(n_valid - v0),   32'd0);
        check("ferr_count",       32'(bus.fifo_count), 32'd0);
        check("ferr_break_busy",  32'(bus.busy_rx),    32'd1);
        bus.rx = 1'b1;
        repeat (6) tick();
        check("ferr_break_exit",  32'(bus.busy_rx),    32'd0);
        check("ferr_no_retrigger",32'(n_ferr - f0),    32'd1);

        // 5. overflow: six frames into a four-entry FIFO
        for (int i = 1; i <= 6; i++) begin
            send_frame(8'(i), 1'b1);
        end
        check("ovf_count_full", 32'(bus.fifo_count), 32'd4);
        check("ovf_flag_set",   32'(bus.overflow),   32'd1);
        for (int i = 1; i <= 4; i++) begin
            recv_tx_byte($sformatf("ovf_tx%0d", i), 8'(i));
        end
        lows = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (bus.tx === 1'b0) lows++;
        end
        check("ovf_dropped_not_sent", 32'(lows),           32'd0);
        check("ovf_count_empty",      32'(bus.fifo_count), 32'd0);
        check("ovf_flag_sticky",      32'(bus.overflow),   32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_flag_cleared",     32'(bus.overflow),   32'd0);

        // 6. reset in the middle of retransmitting 0x5A
        send_frame(8'h5A, 1'b1);
        check("rst5a_rx_data", 32'(bus.rx_data), 32'h5A);
        wait_tx_low("rst5a_tx_timeout", 300);
        repeat (50) tick();
        check("rst5a_busy_tx_mid", 32'(bus.busy_tx), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst5a_tx_high",   32'(bus.tx),         32'd1);
        check("rst5a_count",     32'(bus.fifo_count), 32'd0);
        check("rst5a_busy_tx",   32'(bus.busy_tx),    32'd0);
        check("rst5a_rx_data",   32'(bus.rx_data),    32'd0);
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (bus.tx === 1'b0 || bus.busy_tx === 1'b1) lows++;
        end
        check("rst5a_no_tx_activity", 32'(lows), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_tx.md
Name: uart_rx_fifo_tx

Overview:
- Parametrised UART receive/buffer/retransmit block for the serial front end, on the same 12 MHz system clock.
- Deserialises frames from `rx`, validates start and stop bits, and buffers bytes in an internal FIFO.
- Retransmits buffered bytes on `tx`, either immediately or in bursts after an inter-frame idle gap.
- Adds framing-error detection, glitch rejection, overflow flagging and configurable width/depth/baud.

Parameters:
- CLKS_PER_BIT, 1250, clock cycles per bit (12 MHz / 9600 baud); must be ≥ 4.
- DATA_BITS, 8, data bits per frame (5..9), LSB first, no parity, 1 stop bit.
- FIFO_DEPTH, 16, buffer entries; must be a power of 2, ≥ 2.
- IDLE_BITS, 20, bit-times of continuous line-high in RX idle before `idle` asserts.
- BURST, 1, 1 = TX drains only while `idle`=1; 0 = TX drains whenever FIFO is non-empty.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idle high.
- ovf_clr  in  1  single-cycle clear of `overflow`.
- tx  out  1  serial output; idle high.
- rx_valid  out  1  one-cycle pulse; a good frame was received and pushed.
- rx_data  out  DATA_BITS  last good received word; held until the next good frame.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy_rx  out  1  RX FSM is not in R_IDLE.
- busy_tx  out  1  TX FSM is not in T_IDLE.
- idle  out  1  inter-frame gap detected.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - `tx`=1, `rx_data`=0, and all flags and pulses = 0.
  - FIFO emptied, `fifo_count`=0, both FSMs go to idle, all counters = 0.
  - Synchroniser flops load 1.
  - Reset mid-frame abandons the frame; no partial push; `tx` is high in the cycle after reset.
- RX synchroniser: 2 flops; `rx_s` is `rx` delayed 2 cycles. All RX decisions use `rx_s`.
- RX FSM:
  - R_IDLE: `rx_s`=0 → R_START, bit counter cleared.
  - R_START: at cycle CLKS_PER_BIT/2−1, `rx_s`=0 → R_DATA; `rx_s`=1 → R_IDLE (glitch rejected, no flag).
  - R_DATA: samples `rx_s` every CLKS_PER_BIT cycles, filling the shift register LSB first. After DATA_BITS samples → R_STOP.
  - R_STOP: samples after CLKS_PER_BIT cycles.
    - `rx_s`=1: push the word, pulse `rx_valid`, update `rx_data`, → R_IDLE.
    - `rx_s`=0: pulse `frame_err`, no push, → R_BREAK.
  - R_BREAK: waits for `rx_s`=1, then → R_IDLE. A held-low line never re-triggers a frame.
- Idle detector:
  - Counts consecutive cycles with RX in R_IDLE and `rx_s`=1.
  - At IDLE_BITS*CLKS_PER_BIT, sets `idle`=1 and the counter saturates.
  - `idle` clears in the same cycle RX leaves R_IDLE.
- FIFO (show-ahead):
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - A push when full with no pop drops the byte and sets `overflow`.
  - `overflow` clears on `ovf_clr`; set wins if both happen in the same cycle.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM:
  - T_IDLE, when enabled (BURST=0, or `idle`=1) and FIFO non-empty: pop head into the shift register, → T_START.
  - `tx`=0 from the next cycle.
  - T_START lasts 1 bit-time, then T_DATA sends DATA_BITS bits LSB first, then T_STOP holds `tx`=1 for 1 bit-time, then → T_IDLE.
  - Minimum inter-frame gap is 1 cycle in T_IDLE.
  - A frame in progress always completes even if `idle` drops; new frames start only when enabled.
- Latency:
  - RX: `rx_valid` rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles (±1) after the `rx` falling edge.
  - TX: `tx` falls 2 cycles after the enable condition becomes true.

Decomposition:
- Package `uart_pkg`:
  - RX and TX state encodings (R_IDLE, R_START, R_DATA, R_STOP, R_BREAK, T_IDLE, T_START, T_DATA, T_STOP).
  - Default constants: CLKS_PER_BIT_9600_12M=1250, CLKS_PER_BIT_2400_12M=5000.
- One sub-module, `uart_sync_fifo` (parametrised width/depth, show-ahead, count, full/empty); instantiated once.
- RX FSM, TX FSM and idle detector stay in the top level.

Test Plan:
Bench parameters: CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4, IDLE_BITS=4, BURST=1.
1. Reset: rst=1 for 3 cycles, rx=1 → `tx`=1, `fifo_count`=0, all flags 0; `idle` rises 64 cycles (±3) after rst falls.
2. Send 0xA5 → one `rx_valid` pulse, `rx_data`=0xA5, `fifo_count`=1. After 64 cycles of line-high, `tx` emits 0,1,0,1,0,0,1,0,1,1 (each 16 cycles) and `fifo_count`=0.
3. Drive rx low for 4 cycles, then high → no `rx_valid`, no `frame_err`, `busy_rx` returns to 0 within 10 cycles.
4. Send 0x3C with the stop bit low and hold rx low for 40 more cycles → one `frame_err` pulse, `fifo_count`=0, no new frame until rx high.
5. Send 0x01..0x06 back-to-back → `fifo_count`=4, `overflow`=1, 0x05/0x06 dropped. After the gap, `tx` sends 0x01..0x04 in order. `ovf_clr` pulse → `overflow`=0.
6. Assert rst mid-way through TX of 0x5A → `tx`=1 the next cycle, `fifo_count`=0, no further TX activity.
